// File: rtl/conv_sched_pkg.sv
// Shared types and field layout for the convolution line scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_END  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  // Field layout of the input-shape config register
  localparam int unsigned W_LSB         = 0;
  localparam int unsigned H_LSB         = 8;
  localparam int unsigned SHAPE_FIELD_W = 8;

  localparam int unsigned KERNEL_SIZE_WIDTH_DEF = 2;

endpackage

// File: rtl/sched_wrap_cnt.sv
// Up-counter with enable, synchronous clear and a programmable terminal value;
// wraps to zero on the enabled cycle where it sits at the terminal value.
module sched_wrap_cnt
  import conv_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_last_c,
  output logic             o_wrap_c
);

  logic [WIDTH-1:0] r_cnt;

  assign o_last_c = (r_cnt == i_term);
  assign o_wrap_c = i_en & o_last_c;
  assign o_cnt    = r_cnt;

  // Clear wins over enable so a job start always begins from zero
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last_c ? '0 : r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_line_sched.sv
// Feature-map read sequencer: walks output rows, issuing one W-beat burst per
// kernel line plus an end-of-line pulse. CONV_LINE_SCHED_PERF_EN adds a stall counter.
module conv_line_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned REG_WIDTH         = 32,
  parameter int unsigned KERNEL_SIZE_WIDTH = KERNEL_SIZE_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [REG_WIDTH-1:0] i_conf_inputshape,
  input  logic [REG_WIDTH-1:0] i_conf_kernelshape,
  input  logic                 i_fifo_afull,
  output logic                 o_req,
  output logic                 o_stall,
  output logic                 o_end,
  output logic [CNT_WIDTH-1:0] o_row,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_stall_cycles
);

  localparam int unsigned ROWS_W      = CNT_WIDTH + 1;
  localparam int unsigned STALL_CNT_W = 32;

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [CNT_WIDTH-1:0]         r_w;
  logic [CNT_WIDTH-1:0]         r_h;
  logic [KERNEL_SIZE_WIDTH-1:0] r_k;
  logic                         r_err;

  logic [CNT_WIDTH-1:0]         w_in_w;
  logic [CNT_WIDTH-1:0]         w_in_h;
  logic [KERNEL_SIZE_WIDTH-1:0] w_in_k;
  logic                         w_start_acc;
  logic                         w_cfg_bad;
  logic                         w_go;

  logic [CNT_WIDTH-1:0]         w_beat_term;
  logic [CNT_WIDTH-1:0]         w_line_term;
  logic [ROWS_W-1:0]            w_rows;
  logic [CNT_WIDTH-1:0]         w_row_term;

  logic                         w_beat_en;
  logic                         w_line_en;
  logic                         w_row_en;
  logic                         w_beat_wrap;
  logic                         w_line_wrap;
  logic                         w_row_last;

  logic [CNT_WIDTH-1:0]         w_beat_cnt_unused;
  logic [CNT_WIDTH-1:0]         w_line_cnt_unused;
  logic                         w_beat_last_unused;
  logic                         w_line_last_unused;
  logic                         w_row_wrap_unused;
  logic                         w_cfg_unused;

  // Config field decode
  assign w_in_w = CNT_WIDTH'(i_conf_inputshape[W_LSB +: SHAPE_FIELD_W]);
  assign w_in_h = CNT_WIDTH'(i_conf_inputshape[H_LSB +: SHAPE_FIELD_W]);
  assign w_in_k = i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0];

  assign w_cfg_unused = ^{i_conf_inputshape[REG_WIDTH-1:H_LSB+SHAPE_FIELD_W],
                          i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH],
                          w_beat_cnt_unused, w_line_cnt_unused,
                          w_beat_last_unused, w_line_last_unused, w_row_wrap_unused};

  assign w_start_acc = i_start & (r_state == ST_IDLE);
  assign w_cfg_bad   = (w_in_w == '0) | (w_in_k == '0) | (CNT_WIDTH'(w_in_k) > w_in_h);
  assign w_go        = w_start_acc & ~w_cfg_bad;

  // Terminal values; row count is formed one bit wider so K<=H never underflows
  assign w_beat_term = r_w - CNT_WIDTH'(1);
  assign w_line_term = CNT_WIDTH'(r_k) - CNT_WIDTH'(1);
  assign w_rows      = ROWS_W'(r_h) - ROWS_W'(r_k) + ROWS_W'(1);
  assign w_row_term  = CNT_WIDTH'(w_rows - ROWS_W'(1));

  assign w_beat_en = (r_state == ST_LINE) & ~i_fifo_afull;
  assign w_line_en = (r_state == ST_END);
  assign w_row_en  = w_line_en & w_line_wrap;

  sched_wrap_cnt #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_beat_en),
    .i_clr    (w_go),
    .i_term   (w_beat_term),
    .o_cnt    (w_beat_cnt_unused),
    .o_last_c (w_beat_last_unused),
    .o_wrap_c (w_beat_wrap)
  );

  sched_wrap_cnt #(.WIDTH(CNT_WIDTH)) u_line_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_line_en),
    .i_clr    (w_go),
    .i_term   (w_line_term),
    .o_cnt    (w_line_cnt_unused),
    .o_last_c (w_line_last_unused),
    .o_wrap_c (w_line_wrap)
  );

  sched_wrap_cnt #(.WIDTH(CNT_WIDTH)) u_row_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_row_en),
    .i_clr    (w_go),
    .i_term   (w_row_term),
    .o_cnt    (o_row),
    .o_last_c (w_row_last),
    .o_wrap_c (w_row_wrap_unused)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_state_nxt = w_cfg_bad ? ST_DONE : ST_LINE;
        end
      end
      ST_LINE: begin
        if (w_beat_wrap) begin
          w_state_nxt = ST_END;
        end
      end
      ST_END: begin
        w_state_nxt = (w_line_wrap && w_row_last) ? ST_DONE : ST_LINE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    o_req   = 1'b0;
    o_end   = 1'b0;
    o_done  = 1'b0;
    o_busy  = 1'b0;
    o_stall = 1'b0;
    case (r_state)
      ST_LINE: begin
        o_req   = 1'b1;
        o_busy  = 1'b1;
        o_stall = i_fifo_afull;
      end
      ST_END: begin
        o_end  = 1'b1;
        o_busy = 1'b1;
      end
      ST_DONE: begin
        o_done = 1'b1;
        o_busy = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // Shape latch and sticky error, both refreshed on every accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w   <= '0;
      r_h   <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_w   <= w_in_w;
      r_h   <= w_in_h;
      r_k   <= w_in_k;
      r_err <= w_cfg_bad;
    end
  end

  assign o_err = r_err;

`ifdef CONV_LINE_SCHED_PERF_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Saturating count of back-pressured request cycles
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (o_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cnt;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_line_sched.sv
// Randomized bench for conv_line_sched with a job-level reference model and
// directed scenarios pinned to hand-computed cycle numbers.
module tb_conv_line_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_conf_inputshape = '0;
  logic [31:0] i_conf_kernelshape = '0;
  logic        i_fifo_afull = 1'b0;
  logic        o_req, o_stall, o_end, o_busy, o_done, o_err;
  logic [7:0]  o_row;
  logic [31:0] o_stall_cycles;

  conv_line_sched dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_conf_inputshape  (i_conf_inputshape),
    .i_conf_kernelshape (i_conf_kernelshape),
    .i_fifo_afull       (i_fifo_afull),
    .o_req              (o_req),
    .o_stall            (o_stall),
    .o_end              (o_end),
    .o_row              (o_row),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err),
    .o_stall_cycles     (o_stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Job model: tracks total beats and lines done rather than per-dimension counters
  int     m_mode = 0;   // 0 idle, 1 requesting, 2 end-of-line, 3 completion
  int     m_w = 0, m_k = 0, m_beats = 0, m_ends = 0, m_total = 0;
  bit     m_err = 0;
  longint m_stall = 0;
  int     in_w, in_h, in_k;
  assign in_w = int'(i_conf_inputshape[7:0]);
  assign in_h = int'(i_conf_inputshape[15:8]);
  assign in_k = int'(i_conf_kernelshape[1:0]);

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
    end else begin
      case (m_mode)
        0: if (i_start) begin
          m_w     <= in_w;
          m_k     <= in_k;
          m_stall <= 0;
          m_beats <= 0;
          m_ends  <= 0;
          if (in_w == 0 || in_k == 0 || in_k > in_h) begin
            m_err  <= 1'b1;
            m_mode <= 3;
          end else begin
            m_err   <= 1'b0;
            m_total <= (in_h - in_k + 1) * in_k;
            m_mode  <= 1;
          end
        end
        1: if (i_fifo_afull) begin
          m_stall <= m_stall + 1;
        end else begin
          m_beats <= m_beats + 1;
          if (m_beats + 1 == (m_ends + 1) * m_w) m_mode <= 2;
        end
        2: begin
          m_ends <= m_ends + 1;
          m_mode <= (m_ends + 1 == m_total) ? 3 : 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-job statistics gathered from DUT outputs, relative to the start cycle
  int t0 = 0;
  int j_beats, j_ends, j_first_req, j_first_end, j_last_end, j_done_at, j_max_row;
  bit j_err_done;
  bit cmp_en = 0;

  task automatic clear_stats();
    j_beats = 0; j_ends = 0; j_first_req = -1; j_first_end = -1;
    j_last_end = -1; j_done_at = -1; j_max_row = 0; j_err_done = 0;
  endtask

  always @(negedge clk) begin
    logic [45:0] act_v, exp_v;
    logic [7:0]  exp_row;
    logic [31:0] exp_sc;
    if (cmp_en) begin
      exp_row = ((m_mode == 1 || m_mode == 2) && m_k != 0) ? 8'(m_ends / m_k) : 8'd0;
`ifdef CONV_LINE_SCHED_PERF_EN
      exp_sc = 32'(m_stall);
`else
      exp_sc = 32'd0;
`endif
      act_v = {o_req, o_stall, o_end, o_busy, o_done, o_err, o_row, o_stall_cycles};
      exp_v = {m_mode == 1, (m_mode == 1) && i_fifo_afull, m_mode == 2, m_mode != 0,
               m_mode == 3, m_err, exp_row, exp_sc};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs cycle %0d: got req/stall/end/busy/done/err/row/sc=%h expected %h",
                 cyc, act_v, exp_v);
      end
      if (o_req && !i_fifo_afull) j_beats++;
      if (o_req && j_first_req < 0) j_first_req = cyc - t0;
      if (o_end) begin
        j_ends++;
        if (j_first_end < 0) j_first_end = cyc - t0;
        j_last_end = cyc - t0;
      end
      if (int'(o_row) > j_max_row) j_max_row = int'(o_row);
      if (o_done && j_done_at < 0) begin
        j_done_at  = cyc - t0;
        j_err_done = o_err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stall_mode: 0 none, 1 window [s_lo,s_hi], 2 random; restart_at issues a stray start
  task automatic run_job(input int w, input int h, input int k, input int stall_mode,
                         input int s_lo, input int s_hi, input int restart_at);
    logic [31:0] junk;
    bit ok;
    junk = $urandom();
    i_conf_inputshape  = {junk[31:16], 8'(h), 8'(w)};
    i_conf_kernelshape = {junk[29:0], 2'(k)};
    t0 = cyc;
    clear_stats();
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        i_start = (c == restart_at);
        i_conf_inputshape  = $urandom();
        i_conf_kernelshape = $urandom();
      end else begin
        i_start = 1'b1;
      end
      case (stall_mode)
        1:       i_fifo_afull = (c >= s_lo && c <= s_hi);
        2:       i_fifo_afull = ($urandom_range(3) == 0);
        default: i_fifo_afull = 1'b0;
      endcase
      tick();
      if (j_done_at >= 0) begin
        ok = 1;
        break;
      end
    end
    i_start = 1'b0;
    i_fifo_afull = 1'b0;
    if (!ok) chk("job_timeout", 0, 1);
  endtask

  initial begin
    int w, h, k, exp_lines;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {o_req, o_stall, o_end, o_busy, o_done, o_err, o_row}, 0);
    chk("reset_stall_cycles", o_stall_cycles, 0);
    cmp_en = 1;
    tick();

    // Baseline job W=4 H=4 K=3
    run_job(4, 4, 3, 0, 0, 0, -1);
    chk("base_beats", j_beats, 24);
    chk("base_ends", j_ends, 6);
    chk("base_first_end", j_first_end, 5);
    chk("base_last_end", j_last_end, 30);
    chk("base_done", j_done_at, 31);
    chk("base_max_row", j_max_row, 1);
    @(negedge clk);
    chk("base_busy_low_cycle", cyc - t0, 32);
    chk("base_busy_low", o_busy, 0);
    tick();

    // Three stalled cycles inside the second line
    run_job(4, 4, 3, 1, 7, 9, -1);
    chk("stall_beats", j_beats, 24);
    chk("stall_ends", j_ends, 6);
    chk("stall_done", j_done_at, 34);
    @(negedge clk);
`ifdef CONV_LINE_SCHED_PERF_EN
    chk("stall_cycles", o_stall_cycles, 3);
`else
    chk("stall_cycles", o_stall_cycles, 0);
`endif
    tick();

    // Illegal config K > H
    run_job(2, 2, 3, 0, 0, 0, -1);
    chk("err_done_at", j_done_at, 1);
    chk("err_flag", j_err_done, 1);
    chk("err_no_req", j_first_req, -1);
    chk("err_no_end", j_ends, 0);
    tick();

    // Smallest legal job; also clears the sticky error
    run_job(1, 1, 1, 0, 0, 0, -1);
    chk("min_first_req", j_first_req, 1);
    chk("min_first_end", j_first_end, 2);
    chk("min_done", j_done_at, 3);
    chk("min_err_cleared", o_err, 0);
    tick();

    // Stray start while requesting
    run_job(4, 4, 3, 0, 0, 0, 3);
    chk("restart_beats", j_beats, 24);
    chk("restart_ends", j_ends, 6);
    chk("restart_done", j_done_at, 31);
    tick();

    // Reset in the middle of a job
    i_conf_inputshape  = {16'h0, 8'd4, 8'd4};
    i_conf_kernelshape = 32'd3;
    t0 = cyc;
    clear_stats();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_cycle", cyc - t0, 8);
    chk("midrst_outputs", {o_req, o_stall, o_end, o_busy, o_done, o_err, o_row}, 0);
    chk("midrst_stall_cycles", o_stall_cycles, 0);
    @(posedge clk);
    #1;
    tick();
    chk("midrst_no_done", j_done_at, -1);
    run_job(4, 4, 3, 0, 0, 0, -1);
    chk("midrst_rerun_beats", j_beats, 24);
    chk("midrst_rerun_done", j_done_at, 31);
    tick();

    // Randomized jobs against job-level totals
    for (int j = 0; j < 30; j++) begin
      w = $urandom_range(0, 5);
      h = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      run_job(w, h, k, 2, 0, 0, ($urandom_range(1) == 1) ? int'($urandom_range(1, 12)) : -1);
      if (w == 0 || k == 0 || k > h) begin
        chk("rand_err_done", j_done_at, 1);
        chk("rand_err_flag", j_err_done, 1);
        chk("rand_err_beats", j_beats, 0);
      end else begin
        exp_lines = (h - k + 1) * k;
        chk("rand_beats", j_beats, exp_lines * w);
        chk("rand_ends", j_ends, exp_lines);
        chk("rand_err_flag", j_err_done, 0);
      end
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        i_fifo_afull = $urandom_range(1);
        tick();
      end
      i_fifo_afull = 1'b0;
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
